// File: rtl/cpu_pkg.sv
// cpu_pkg: shared data-cache types and address-split constants for the MEM stage.
// Contents: dc_state_e cache FSM states, address field LSBs, line geometry.
package cpu_pkg;
   typedef enum logic [1:0] {
      DC_IDLE,
      DC_WRITEBACK,
      DC_ALLOCATE,
      DC_REFILL_DONE
   } dc_state_e;
   localparam int WORD_SEL_LSB = 2;
   localparam int INDEX_LSB    = 5;
   localparam int TAG_LSB      = 10;
   localparam int LINE_W       = 256;
   localparam int NUM_LINES    = 32;
   localparam int IDX_W        = 5;
   localparam int TAG_W        = 22;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: flop-based valid/dirty/tag/data arrays of the direct-mapped data cache.
// Ports:
//   clk_i, rst_i   clock and synchronous active-low reset (clears valid and dirty only)
//   i_idx          line index shared by the read and write ports
//   o_valid/o_dirty/o_tag/o_line  combinational read of line i_idx
//   i_fill, i_fill_tag, i_fill_line  install a whole line: valid=1, dirty=0
//   i_word_we, i_word_sel, i_wdata   write one 32-bit word and set dirty
//   i_clr_dirty    clear dirty after the victim has been written back
module dcache_sram
   import cpu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  i_idx,
   output logic              o_valid,
   output logic              o_dirty,
   output logic [TAG_W-1:0]  o_tag,
   output logic [LINE_W-1:0] o_line,
   input  logic              i_fill,
   input  logic [TAG_W-1:0]  i_fill_tag,
   input  logic [LINE_W-1:0] i_fill_line,
   input  logic              i_word_we,
   input  logic [2:0]        i_word_sel,
   input  logic [31:0]       i_wdata,
   input  logic              i_clr_dirty
);
   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [LINE_W-1:0]    r_data [NUM_LINES];

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_data[i_idx];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_word_we) begin
         r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
         r_dirty[i_idx] <= 1'b0;
      end
   end

   // Tag and data carry no reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk_i) begin
      if (rst_i && i_fill) begin
         r_tag[i_idx]  <= i_fill_tag;
         r_data[i_idx] <= i_fill_line;
      end else if (rst_i && i_word_we) begin
         r_data[i_idx][{i_word_sel, 5'b0} +: 32] <= i_wdata;
      end
   end
endmodule

// File: rtl/dcache_wb_dm.sv
// dcache_wb_dm: direct-mapped write-back write-allocate data cache with pipeline stall.
// Ports:
//   clk_i, rst_i         clock and synchronous active-low reset
//   cpu_req_i/we_i       MEM-stage access valid / store select
//   cpu_addr_i/wdata_i   byte address (held during stall) and store data
//   cpu_rdata_o          load-hit data, zero otherwise
//   stall_o              freezes the pipeline while a miss is serviced
//   mem_req_o/we_o       registered line request (write-back or fill), held until mem_ack_i
//   mem_addr_o/wdata_o   line-aligned address and victim line
//   mem_ack_i/rdata_i    one-cycle completion pulse and fill data
module dcache_wb_dm
   import cpu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_rdata_i
);
   dc_state_e         r_state, w_state_nxt;
   logic              r_mem_req, r_mem_we;
   logic [31:0]       r_mem_addr;
   logic [LINE_W-1:0] r_mem_wdata;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag, w_vtag;
   logic [2:0]        w_word;
   logic              w_valid, w_dirty, w_match, w_idle, w_hit, w_miss, w_victim_dirty;
   logic [LINE_W-1:0] w_line;
   logic              w_unused_addr;

   assign w_idx          = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
   assign w_tag          = cpu_addr_i[31:TAG_LSB];
   assign w_word         = cpu_addr_i[INDEX_LSB-1:WORD_SEL_LSB];
   assign w_unused_addr  = &{1'b0, cpu_addr_i[1:0]};
   assign w_idle         = r_state == DC_IDLE;
   assign w_match        = w_valid && w_tag == w_vtag;
   assign w_hit          = cpu_req_i && w_idle && w_match;
   assign w_miss         = cpu_req_i && w_idle && !w_match;
   assign w_victim_dirty = w_valid && w_dirty;

   // w_hit already implies IDLE, so this equals req & (!hit | state != IDLE).
   assign stall_o     = cpu_req_i && !w_hit;
   assign cpu_rdata_o = (w_hit && !cpu_we_i) ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_idx       (w_idx),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_vtag),
      .o_line      (w_line),
      .i_fill      (r_state == DC_ALLOCATE && mem_ack_i),
      .i_fill_tag  (w_tag),
      .i_fill_line (mem_rdata_i),
      .i_word_we   (w_hit && cpu_we_i),
      .i_word_sel  (w_word),
      .i_wdata     (cpu_wdata_i),
      .i_clr_dirty (r_state == DC_WRITEBACK && mem_ack_i)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) r_state <= DC_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DC_IDLE:      if (w_miss) w_state_nxt = w_victim_dirty ? DC_WRITEBACK : DC_ALLOCATE;
         DC_WRITEBACK: if (mem_ack_i) w_state_nxt = DC_ALLOCATE;
         DC_ALLOCATE:  if (mem_ack_i) w_state_nxt = DC_REFILL_DONE;
         default:      w_state_nxt = DC_IDLE;
      endcase
   end

   // Request registers: launched on the missing IDLE cycle, retargeted to the fill
   // after the write-back ack, dropped the cycle after the fill ack.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            DC_IDLE: if (w_miss) begin
               r_mem_req   <= 1'b1;
               r_mem_we    <= w_victim_dirty;
               r_mem_addr  <= {w_victim_dirty ? w_vtag : w_tag, w_idx, 5'b0};
               r_mem_wdata <= w_line;
            end
            DC_WRITEBACK: if (mem_ack_i) begin
               r_mem_we   <= 1'b0;
               r_mem_addr <= {w_tag, w_idx, 5'b0};
            end
            DC_ALLOCATE: if (mem_ack_i) r_mem_req <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_wb_dm.sv
// tb_dcache_wb_dm: directed self-checking bench for dcache_wb_dm.
module tb_dcache_wb_dm;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         cpu_req_i = 1'b0, cpu_we_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0, cpu_wdata_i = '0;
   logic [31:0]  cpu_rdata_o;
   logic         stall_o, mem_req_o, mem_we_o, mem_ack_i = 1'b0;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o, mem_rdata_i = '0;
   int           n_chk = 0, n_err = 0;
   logic [255:0] l1, l1m, l2, l3, l3m, l4, l5;

   dcache_wb_dm dut (
      .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
      .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d);
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
      #1;
   endtask

   task automatic ack(input logic [255:0] line);
      mem_ack_i = 1'b1; mem_rdata_i = line;
      step();
      mem_ack_i = 1'b0; mem_rdata_i = '0;
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   initial begin
      l1 = mk_line(32'h1000_0000); l1[95:64] = 32'hDEAD_BEEF;
      l1m = l1; l1m[63:32] = 32'h1234_5678;
      l2 = mk_line(32'hCAFE_0000);
      l3 = mk_line(32'h3333_0000);
      l3m = l3; l3m[31:0] = 32'hA5A5_A5A5;
      l4 = mk_line(32'h4444_0000);
      l5 = mk_line(32'h5555_0000);
      repeat (2) step();
      chk("rst_req", mem_req_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_rdata", cpu_rdata_o, 0);
      rst_i = 1'b1;
      // 1: cold load miss, clean fill of line 0x40
      acc(0, 32'h48, 0);
      chk("t1_stall_miss", stall_o, 1);
      chk("t1_req_not_yet", mem_req_o, 0);
      step();
      chk("t1_req", mem_req_o, 1);
      chk("t1_we", mem_we_o, 0);
      chk("t1_addr", mem_addr_o, 32'h40);
      chk("t1_stall_alloc", stall_o, 1);
      repeat (4) step();
      chk("t1_req_held", mem_req_o, 1);
      ack(l1);
      chk("t1_bubble_stall", stall_o, 1);
      chk("t1_req_drop", mem_req_o, 0);
      chk("t1_bubble_rdata", cpu_rdata_o, 0);
      step();
      chk("t1_hit_stall", stall_o, 0);
      chk("t1_rdata", cpu_rdata_o, 32'hDEAD_BEEF);
      // 2: store hit then load it back
      acc(1, 32'h44, 32'h1234_5678);
      chk("t2_st_stall", stall_o, 0);
      chk("t2_st_rdata", cpu_rdata_o, 0);
      step();
      acc(0, 32'h44, 0);
      chk("t2_ld", cpu_rdata_o, 32'h1234_5678);
      // 6: back-to-back hits
      step();
      acc(0, 32'h40, 0);
      chk("t6_stall0", stall_o, 0);
      chk("t6_d0", cpu_rdata_o, 32'h1000_0000);
      step();
      acc(0, 32'h44, 0);
      chk("t6_stall1", stall_o, 0);
      chk("t6_d1", cpu_rdata_o, 32'h1234_5678);
      step();
      acc(0, 32'h48, 0);
      chk("t6_stall2", stall_o, 0);
      chk("t6_d2", cpu_rdata_o, 32'hDEAD_BEEF);
      step();
      // 3: conflict miss with dirty victim
      acc(0, 32'h440, 0);
      chk("t3_stall", stall_o, 1);
      step();
      chk("t3_wb_req", mem_req_o, 1);
      chk("t3_wb_we", mem_we_o, 1);
      chk("t3_wb_addr", mem_addr_o, 32'h40);
      chk("t3_wb_word1", mem_wdata_o[63:32], 32'h1234_5678);
      chk("t3_wb_line", mem_wdata_o, l1m);
      repeat (2) step();
      chk("t3_wb_hold", mem_addr_o, 32'h40);
      ack('0);
      chk("t3_fill_req", mem_req_o, 1);
      chk("t3_fill_we", mem_we_o, 0);
      chk("t3_fill_addr", mem_addr_o, 32'h440);
      chk("t3_fill_stall", stall_o, 1);
      ack(l2);
      chk("t3_bubble", stall_o, 1);
      step();
      chk("t3_stall_done", stall_o, 0);
      chk("t3_rdata", cpu_rdata_o, 32'hCAFE_0000);
      step();
      // 4: store miss, clean victim, then eviction writes it back
      acc(1, 32'h80, 32'hA5A5_A5A5);
      chk("t4_stall", stall_o, 1);
      step();
      chk("t4_we", mem_we_o, 0);
      chk("t4_addr", mem_addr_o, 32'h80);
      ack(l3);
      step();
      chk("t4_st_stall", stall_o, 0);
      step();
      acc(0, 32'h80, 0);
      chk("t4_ld0", cpu_rdata_o, 32'hA5A5_A5A5);
      step();
      acc(0, 32'h84, 0);
      chk("t4_ld1", cpu_rdata_o, 32'h3333_0001);
      step();
      acc(0, 32'h880, 0);
      chk("t4_ev_stall", stall_o, 1);
      step();
      chk("t4_ev_we", mem_we_o, 1);
      chk("t4_ev_addr", mem_addr_o, 32'h80);
      chk("t4_ev_line", mem_wdata_o, l3m);
      ack('0);
      chk("t4_ev_fill_addr", mem_addr_o, 32'h880);
      ack(l4);
      step();
      chk("t4_ev_rdata", cpu_rdata_o, 32'h4444_0000);
      step();
      // 5: reset during ALLOCATE, late ack ignored
      acc(0, 32'h100, 0);
      step();
      chk("t5_req", mem_req_o, 1);
      rst_i = 1'b0; cpu_req_i = 1'b0;
      step();
      rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = l5;
      #1;
      chk("t5_rst_req", mem_req_o, 0);
      chk("t5_rst_addr", mem_addr_o, 0);
      chk("t5_rst_stall", stall_o, 0);
      step();
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      chk("t5_late_ack", mem_req_o, 0);
      acc(0, 32'h100, 0);
      chk("t5_remiss", stall_o, 1);
      step();
      chk("t5_refill_req", mem_req_o, 1);
      chk("t5_refill_addr", mem_addr_o, 32'h100);
      ack(l5);
      step();
      chk("t5_rdata", cpu_rdata_o, 32'h5555_0000);
      step();
      acc(0, 32'h48, 0);
      chk("t5_cleared_miss", stall_o, 1);
      cpu_req_i = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
